epass_fee_unit: RTL and testbench

- Toll-lane E-pass validation stage. Consumes init/count/cal from the lane controller and returns valid_Epass and done to it.
- Measures sensor1-to-sensor2 transit time, computes the toll fee and looks up the card balance in an internal balance table.
- Deducts the fee on acceptance and reports accept or reject.
- Provides a top-up port for the balance table.

---
 rtl/epass_fee_unit_if.sv | 33 +++
 rtl/epass_fee_unit.sv | 217 +++++++++++++++++++++
 tb/tb_epass_fee_unit.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/epass_fee_unit_if.sv
// Lane-controller <-> E-pass fee unit bus: phase strobes, card reader, top-up port, result.
// Latency: none, wires only.
// Backpressure: none; every strobe is a single-cycle event that the fee unit always accepts.
// Ports (master = controller/reader side, slave = fee unit):
//   init, count, cal, card_valid, card_id, topup_en, topup_id, topup_amt  master -> slave
//   valid_Epass, done, fee, transit_ticks                                slave  -> master
interface epass_fee_unit_if #(
    parameter int ID_W  = 3,
    parameter int BAL_W = 12
);
    logic              init;
    logic              count;
    logic              cal;
    logic              card_valid;
    logic [ID_W-1:0]   card_id;
    logic              topup_en;
    logic [ID_W-1:0]   topup_id;
    logic [BAL_W-1:0]  topup_amt;
    logic [1:0]        valid_Epass;
    logic              done;
    logic [BAL_W-1:0]  fee;
    logic [15:0]       transit_ticks;

    modport master (
        output init, count, cal, card_valid, card_id, topup_en, topup_id, topup_amt,
        input  valid_Epass, done, fee, transit_ticks
    );

    modport slave (
        input  init, count, cal, card_valid, card_id, topup_en, topup_id, topup_amt,
        output valid_Epass, done, fee, transit_ticks
    );
endinterface

// File: rtl/epass_fee_unit.sv
// Toll-lane E-pass stage: transit timer, fee computation, balance table with deduct and top-up.
// Latency: cal -> valid_Epass=11 in 1 cycle; card_valid -> done/result in 2 cycles.
// Backpressure: none; result is held in RESULT until the controller asserts init.
// Ports: clk, reset_n (async active-low), bus (epass_fee_unit_if.slave).
// Optional feature macro SPEED_FINE_EN: adds FINE to the fee when transit_ticks < MIN_TIME at cal.
module epass_fee_unit #(
    parameter int NUM_CARDS = 8,
    parameter int ID_W      = 3,
    parameter int BAL_W     = 12,
    parameter int INIT_BAL  = 100,
    parameter int BASE_FEE  = 20,
    parameter int TICK_DIV  = 1000,
    parameter int MIN_TIME  = 5,
    parameter int FINE      = 50,
    parameter int TIMEOUT   = 200
) (
    input  logic             clk,
    input  logic             reset_n,
    epass_fee_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_CARD,
        S_CHECK,
        S_RESULT
    } state_t;

    localparam logic [BAL_W-1:0] BAL_MAX = '1;
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    // Clamp a constant into the balance range.
    function automatic logic [BAL_W-1:0] sat_bal(input longint v);
        if (v > longint'(BAL_MAX)) return BAL_MAX;
        return v[BAL_W-1:0];
    endfunction

    function automatic logic [BAL_W-1:0] sat_add(input logic [BAL_W-1:0] a,
                                                 input logic [BAL_W-1:0] b);
        logic [BAL_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[BAL_W] ? BAL_MAX : s[BAL_W-1:0];
    endfunction

    localparam logic [BAL_W-1:0] INIT_BAL_V = sat_bal(longint'(INIT_BAL));
    localparam logic [BAL_W-1:0] FEE_BASE   = sat_bal(longint'(BASE_FEE));
`ifdef SPEED_FINE_EN
    localparam logic [BAL_W-1:0] FEE_FINED  = sat_bal(longint'(BASE_FEE) + longint'(FINE));
`endif

    state_t            state_q, state_d;
    logic [1:0]        vld_epass_q, vld_epass_d;
    logic              done_q, done_d;
    logic [BAL_W-1:0]  fee_q, fee_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [15:0]       ticks_q, ticks_d;
    logic [PRE_W-1:0]  to_pre_q, to_pre_d;
    logic [TO_W-1:0]   to_ticks_q, to_ticks_d;
    logic [BAL_W-1:0]  bal_q [NUM_CARDS];
    logic [BAL_W-1:0]  bal_d [NUM_CARDS];

    logic [BAL_W-1:0]  fee_calc;
    logic              card_known;
    logic [BAL_W-1:0]  card_bal;
    logic              deduct;

    // Fee is frozen from the transit time seen on the cal cycle.
    always_comb begin
`ifdef SPEED_FINE_EN
        fee_calc = (int'(ticks_q) < MIN_TIME) ? FEE_FINED : FEE_BASE;
`else
        fee_calc = FEE_BASE;
`endif
    end

    // Balance of the latched card; ids beyond the table read as unknown.
    always_comb begin
        card_known = 1'b0;
        card_bal   = '0;
        for (int i = 0; i < NUM_CARDS; i++) begin
            if (id_q == ID_W'(i)) begin
                card_known = 1'b1;
                card_bal   = bal_q[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        vld_epass_d = vld_epass_q;
        done_d      = 1'b0;
        fee_d       = fee_q;
        id_d        = id_q;
        pre_d       = pre_q;
        ticks_d     = ticks_q;
        to_pre_d    = to_pre_q;
        to_ticks_d  = to_ticks_q;
        deduct      = 1'b0;

        // Transit timer: runs on count, cleared by init, saturates.
        if (bus.init) begin
            pre_d   = '0;
            ticks_d = '0;
        end else if (bus.count) begin
            if (pre_q == PRE_W'(TICK_DIV - 1)) begin
                pre_d = '0;
                if (ticks_q != 16'hFFFF) ticks_d = ticks_q + 16'd1;
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                vld_epass_d = 2'b00;
                if (bus.cal) begin
                    fee_d       = fee_calc;
                    vld_epass_d = 2'b11;
                    to_pre_d    = '0;
                    to_ticks_d  = '0;
                    state_d     = S_WAIT_CARD;
                end
            end
            S_WAIT_CARD: begin
                // init wins over a card read in the same cycle.
                if (bus.init) begin
                    vld_epass_d = 2'b00;
                    state_d     = S_IDLE;
                end else if (bus.card_valid) begin
                    id_d    = bus.card_id;
                    state_d = S_CHECK;
                end else if (to_pre_q == PRE_W'(TICK_DIV - 1)) begin
                    to_pre_d = '0;
                    if (to_ticks_q == TO_W'(TIMEOUT - 1)) begin
                        vld_epass_d = 2'b01;
                        done_d      = 1'b1;
                        state_d     = S_RESULT;
                    end else begin
                        to_ticks_d = to_ticks_q + TO_W'(1);
                    end
                end else begin
                    to_pre_d = to_pre_q + PRE_W'(1);
                end
            end
            S_CHECK: begin
                if (bus.init) begin
                    vld_epass_d = 2'b00;
                    state_d     = S_IDLE;
                end else begin
                    done_d  = 1'b1;
                    state_d = S_RESULT;
                    // Sufficiency uses the balance before any same-cycle top-up.
                    if (card_known && (card_bal >= fee_q)) begin
                        vld_epass_d = 2'b10;
                        deduct      = 1'b1;
                    end else begin
                        vld_epass_d = 2'b01;
                    end
                end
            end
            S_RESULT: begin
                if (bus.init) begin
                    vld_epass_d = 2'b00;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                vld_epass_d = 2'b00;
                state_d     = S_IDLE;
            end
        endcase

        // Top-up applies first, then the deduction: sat(bal + amt) - fee.
        // No underflow: deduct implies bal >= fee and the top-up only grows bal.
        for (int i = 0; i < NUM_CARDS; i++) begin
            bal_d[i] = bal_q[i];
            if (bus.topup_en && (bus.topup_id == ID_W'(i)))
                bal_d[i] = sat_add(bal_d[i], bus.topup_amt);
            if (deduct && (id_q == ID_W'(i)))
                bal_d[i] = bal_d[i] - fee_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            vld_epass_q <= 2'b00;
            done_q      <= 1'b0;
            fee_q       <= '0;
            id_q        <= '0;
            pre_q       <= '0;
            ticks_q     <= '0;
            to_pre_q    <= '0;
            to_ticks_q  <= '0;
            for (int i = 0; i < NUM_CARDS; i++) bal_q[i] <= INIT_BAL_V;
        end else begin
            state_q     <= state_d;
            vld_epass_q <= vld_epass_d;
            done_q      <= done_d;
            fee_q       <= fee_d;
            id_q        <= id_d;
            pre_q       <= pre_d;
            ticks_q     <= ticks_d;
            to_pre_q    <= to_pre_d;
            to_ticks_q  <= to_ticks_d;
            for (int i = 0; i < NUM_CARDS; i++) bal_q[i] <= bal_d[i];
        end
    end

    assign bus.valid_Epass   = vld_epass_q;
    assign bus.done          = done_q;
    assign bus.fee           = fee_q;
    assign bus.transit_ticks = ticks_q;

endmodule

// File: tb/tb_epass_fee_unit.sv
// Self-checking bench for epass_fee_unit against a transaction-level balance/fee model.
// Latency: n/a.
// Backpressure: n/a.
module tb_epass_fee_unit;

    localparam int NC    = 6;
    localparam int IDW   = 3;
    localparam int BW    = 12;
    localparam int INITB = 100;
    localparam int BASE  = 20;
    localparam int TDIV  = 4;
    localparam int MINT  = 5;
    localparam int FINEV = 50;
    localparam int TOUT  = 200;
    localparam int BMAX  = (1 << BW) - 1;
`ifdef SPEED_FINE_EN
    localparam bit FINE_ON = 1'b1;
`else
    localparam bit FINE_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    epass_fee_unit_if #(.ID_W(IDW), .BAL_W(BW)) bus ();

    epass_fee_unit #(
        .NUM_CARDS(NC), .ID_W(IDW), .BAL_W(BW), .INIT_BAL(INITB), .BASE_FEE(BASE),
        .TICK_DIV(TDIV), .MIN_TIME(MINT), .FINE(FINEV), .TIMEOUT(TOUT)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int mbal [NC];

    typedef struct {
        logic [1:0]    vcal;
        logic [BW-1:0] fee;
        logic [15:0]   tt;
        logic          d0, d1, d2;
        logic [1:0]    v1, v2;
    } obs_t;

    // ---------------- reference model ----------------
    function automatic int model_fee(input int ticks);
        int f;
        f = (FINE_ON && ticks < MINT) ? BASE + FINEV : BASE;
        return (f > BMAX) ? BMAX : f;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NC; i++) mbal[i] = INITB;
    endfunction

    function automatic void model_topup(input int tid, input int amt);
        if (tid < NC) mbal[tid] = (mbal[tid] + amt > BMAX) ? BMAX : mbal[tid] + amt;
    endfunction

    // Returns 1 on accept; top-up (if any) lands in the same step as the deduction.
    function automatic bit model_txn(input int id, input int fee, input bit ten,
                                     input int tid, input int tamt);
        bit acc;
        acc = (id < NC) && (mbal[id] >= fee);
        if (ten) model_topup(tid, tamt);
        if (acc) mbal[id] = mbal[id] - fee;
        return acc;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_timer(input int n);
        bus.init = 1'b1;
        tick();
        bus.init  = 1'b0;
        bus.count = 1'b1;
        repeat (n * TDIV) tick();
        bus.count = 1'b0;
    endtask

    task automatic do_cal(output logic [1:0] v, output logic [BW-1:0] f);
        bus.cal = 1'b1;
        tick();
        bus.cal = 1'b0;
        v = bus.valid_Epass;
        f = bus.fee;
    endtask

    task automatic do_topup_idle(input int tid, input int amt);
        bus.topup_en  = 1'b1;
        bus.topup_id  = IDW'(tid);
        bus.topup_amt = BW'(amt);
        tick();
        bus.topup_en = 1'b0;
    endtask

    // Full transaction: timer, cal, card read, optional top-up in the CHECK cycle.
    task automatic txn(input int ticks, input int id, input bit ten, input int tid,
                       input int tamt, output obs_t o);
        run_timer(ticks);
        o.tt = bus.transit_ticks;
        do_cal(o.vcal, o.fee);
        bus.card_valid = 1'b1;
        bus.card_id    = IDW'(id);
        tick();
        bus.card_valid = 1'b0;
        o.d0 = bus.done;
        bus.topup_en  = ten;
        bus.topup_id  = IDW'(tid);
        bus.topup_amt = BW'(tamt);
        tick();
        bus.topup_en = 1'b0;
        o.d1 = bus.done;
        o.v1 = bus.valid_Epass;
        tick();
        o.d2 = bus.done;
        o.v2 = bus.valid_Epass;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        n_cmp++;
        if (bus.valid_Epass !== 2'b00) begin n_fail++; $display("FAIL reset_valid got %b want 00", bus.valid_Epass); end
        n_cmp++;
        if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
        n_cmp++;
        if (bus.fee !== '0) begin n_fail++; $display("FAIL reset_fee got %0d want 0", bus.fee); end
        n_cmp++;
        if (bus.transit_ticks !== 16'd0) begin n_fail++; $display("FAIL reset_ticks got %0d want 0", bus.transit_ticks); end
        for (int i = 0; i < NC; i++) begin
            n_cmp++;
            if (int'(dut.bal_q[i]) !== mbal[i]) begin n_fail++; $display("FAIL reset_bal[%0d] got %0d want %0d", i, dut.bal_q[i], mbal[i]); end
        end
    endtask

    task automatic test_nominal();
        obs_t o;
        int   f;
        f = model_fee(10);
        txn(10, 2, 1'b0, 0, 0, o);
        void'(model_txn(2, f, 1'b0, 0, 0));
        n_cmp++;
        if (o.tt !== 16'd10) begin n_fail++; $display("FAIL nom_ticks got %0d want 10", o.tt); end
        n_cmp++;
        if (o.vcal !== 2'b11) begin n_fail++; $display("FAIL nom_busy got %b want 11", o.vcal); end
        n_cmp++;
        if (int'(o.fee) !== 20) begin n_fail++; $display("FAIL nom_fee got %0d want 20", o.fee); end
        n_cmp++;
        if ({o.d0, o.d1, o.d2} !== 3'b010) begin n_fail++; $display("FAIL nom_done_seq got %b want 010", {o.d0, o.d1, o.d2}); end
        n_cmp++;
        if (o.v1 !== 2'b10 || o.v2 !== 2'b10) begin n_fail++; $display("FAIL nom_accept got %b/%b want 10/10", o.v1, o.v2); end
        repeat (5) tick();
        n_cmp++;
        if (bus.valid_Epass !== 2'b10 || int'(bus.fee) !== 20) begin n_fail++; $display("FAIL nom_hold got %b fee %0d want 10 fee 20", bus.valid_Epass, bus.fee); end
        n_cmp++;
        if (int'(dut.bal_q[2]) !== 80) begin n_fail++; $display("FAIL nom_bal2 got %0d want 80", dut.bal_q[2]); end
        bus.init = 1'b1;
        tick();
        bus.init = 1'b0;
        n_cmp++;
        if (bus.valid_Epass !== 2'b00) begin n_fail++; $display("FAIL nom_release got %b want 00", bus.valid_Epass); end
    endtask

    task automatic test_insufficient();
        obs_t o;
        for (int k = 0; k < 6; k++) begin
            bit acc;
            acc = model_txn(3, model_fee(10), 1'b0, 0, 0);
            txn(10, 3, 1'b0, 0, 0, o);
            n_cmp++;
            if (o.v1 !== (acc ? 2'b10 : 2'b01) || o.d1 !== 1'b1) begin
                n_fail++; $display("FAIL insuf_txn%0d got %b done %b want %b done 1", k, o.v1, o.d1, acc ? 2'b10 : 2'b01);
            end
        end
        n_cmp++;
        if (o.v1 !== 2'b01) begin n_fail++; $display("FAIL insuf_reject got %b want 01", o.v1); end
        n_cmp++;
        if (int'(dut.bal_q[3]) !== 0) begin n_fail++; $display("FAIL insuf_bal3 got %0d want 0", dut.bal_q[3]); end
    endtask

    task automatic test_unknown_timeout();
        obs_t          o;
        logic [1:0]    v;
        logic [BW-1:0] f;
        bit            got;
        int            cyc;
        txn(10, 7, 1'b0, 0, 0, o);
        n_cmp++;
        if (o.v1 !== 2'b01 || o.d1 !== 1'b1) begin n_fail++; $display("FAIL unknown_card got %b done %b want 01 done 1", o.v1, o.d1); end

        run_timer(10);
        do_cal(v, f);
        got = 1'b0;
        cyc = 0;
        for (int k = 1; k <= 3 * TOUT * TDIV && !got; k++) begin
            tick();
            if (bus.done === 1'b1) begin got = 1'b1; cyc = k; v = bus.valid_Epass; end
        end
        n_cmp++;
        if (!got) begin
            n_fail++; $display("FAIL timeout_done got none want pulse within %0d cycles", 3 * TOUT * TDIV);
        end else begin
            n_cmp++;
            if (cyc < TOUT * TDIV - 1 || cyc > TOUT * TDIV + 1) begin n_fail++; $display("FAIL timeout_cycles got %0d want %0d", cyc, TOUT * TDIV); end
            n_cmp++;
            if (v !== 2'b01) begin n_fail++; $display("FAIL timeout_valid got %b want 01", v); end
            tick();
            n_cmp++;
            if (bus.done !== 1'b0 || bus.valid_Epass !== 2'b01) begin n_fail++; $display("FAIL timeout_after got done %b valid %b want 0/01", bus.done, bus.valid_Epass); end
        end
        for (int i = 0; i < NC; i++) begin
            n_cmp++;
            if (int'(dut.bal_q[i]) !== mbal[i]) begin n_fail++; $display("FAIL timeout_bal[%0d] got %0d want %0d", i, dut.bal_q[i], mbal[i]); end
        end
    endtask

    task automatic test_speeding();
        obs_t o;
        int   f;
        f = model_fee(3);
        void'(model_txn(1, f, 1'b0, 0, 0));
        txn(3, 1, 1'b0, 0, 0, o);
        n_cmp++;
        if (int'(o.fee) !== (FINE_ON ? 70 : 20)) begin n_fail++; $display("FAIL speed_fee got %0d want %0d", o.fee, FINE_ON ? 70 : 20); end
        n_cmp++;
        if (int'(dut.bal_q[1]) !== (FINE_ON ? 30 : 80)) begin n_fail++; $display("FAIL speed_bal1 got %0d want %0d", dut.bal_q[1], FINE_ON ? 30 : 80); end
    endtask

    task automatic test_topup_deduct();
        obs_t o;
        bit   acc;
        // Drain card 4 to 0, top it up to 10.
        for (int k = 0; k < 5; k++) begin
            void'(model_txn(4, model_fee(10), 1'b0, 0, 0));
            txn(10, 4, 1'b0, 0, 0, o);
        end
        model_topup(4, 10);
        do_topup_idle(4, 10);
        acc = model_txn(4, model_fee(10), 1'b1, 4, 100);
        txn(10, 4, 1'b1, 4, 100, o);
        n_cmp++;
        if (o.v1 !== 2'b01 || acc) begin n_fail++; $display("FAIL topup_low got %b want 01", o.v1); end
        n_cmp++;
        if (int'(dut.bal_q[4]) !== 110) begin n_fail++; $display("FAIL topup_low_bal got %0d want 110", dut.bal_q[4]); end
        // 110 -> 30 with four accepts, then accept with concurrent top-up.
        for (int k = 0; k < 4; k++) begin
            void'(model_txn(4, model_fee(10), 1'b0, 0, 0));
            txn(10, 4, 1'b0, 0, 0, o);
        end
        acc = model_txn(4, model_fee(10), 1'b1, 4, 100);
        txn(10, 4, 1'b1, 4, 100, o);
        n_cmp++;
        if (o.v1 !== 2'b10) begin n_fail++; $display("FAIL topup_ok got %b want 10", o.v1); end
        n_cmp++;
        if (int'(dut.bal_q[4]) !== 110) begin n_fail++; $display("FAIL topup_ok_bal got %0d want 110", dut.bal_q[4]); end
        // Saturation and unknown-id top-ups.
        model_topup(5, BMAX);
        do_topup_idle(5, BMAX);
        model_topup(7, 55);
        do_topup_idle(7, 55);
        for (int i = 0; i < NC; i++) begin
            n_cmp++;
            if (int'(dut.bal_q[i]) !== mbal[i]) begin n_fail++; $display("FAIL topup_bal[%0d] got %0d want %0d", i, dut.bal_q[i], mbal[i]); end
        end
    endtask

    task automatic test_abort();
        logic [1:0]    v;
        logic [BW-1:0] f;
        // Stray card read while idle.
        run_timer(10);
        bus.card_valid = 1'b1;
        bus.card_id    = 3'd0;
        tick();
        bus.card_valid = 1'b0;
        tick();
        n_cmp++;
        if (bus.valid_Epass !== 2'b00 || bus.done !== 1'b0) begin n_fail++; $display("FAIL idle_card got %b done %b want 00/0", bus.valid_Epass, bus.done); end
        // init together with card_valid in WAIT_CARD.
        do_cal(v, f);
        bus.card_valid = 1'b1;
        bus.init       = 1'b1;
        tick();
        bus.card_valid = 1'b0;
        bus.init       = 1'b0;
        n_cmp++;
        if (bus.valid_Epass !== 2'b00 || bus.done !== 1'b0) begin n_fail++; $display("FAIL abort_wait got %b done %b want 00/0", bus.valid_Epass, bus.done); end
        tick();
        n_cmp++;
        if (bus.done !== 1'b0) begin n_fail++; $display("FAIL abort_wait_late got done %b want 0", bus.done); end
        // init during CHECK.
        do_cal(v, f);
        bus.card_valid = 1'b1;
        tick();
        bus.card_valid = 1'b0;
        bus.init       = 1'b1;
        tick();
        bus.init = 1'b0;
        n_cmp++;
        if (bus.valid_Epass !== 2'b00 || bus.done !== 1'b0) begin n_fail++; $display("FAIL abort_check got %b done %b want 00/0", bus.valid_Epass, bus.done); end
        for (int i = 0; i < NC; i++) begin
            n_cmp++;
            if (int'(dut.bal_q[i]) !== mbal[i]) begin n_fail++; $display("FAIL abort_bal[%0d] got %0d want %0d", i, dut.bal_q[i], mbal[i]); end
        end
    endtask

    task automatic test_random();
        obs_t o;
        for (int k = 0; k < 25; k++) begin
            int ticks, id, tid, tamt, f;
            bit ten, acc;
            ticks = $urandom_range(8, 1);
            id    = $urandom_range(7, 0);
            ten   = ($urandom_range(2, 0) == 0);
            tid   = $urandom_range(7, 0);
            tamt  = $urandom_range(300, 0);
            if ($urandom_range(3, 0) == 0) begin
                int a;
                a = $urandom_range(60, 0);
                model_topup(id, a);
                do_topup_idle(id, a);
            end
            f   = model_fee(ticks);
            acc = model_txn(id, f, ten, tid, tamt);
            txn(ticks, id, ten, tid, tamt, o);
            n_cmp++;
            if (int'(o.tt) !== ticks || int'(o.fee) !== f || o.vcal !== 2'b11) begin
                n_fail++; $display("FAIL rnd%0d_setup got ticks %0d fee %0d busy %b want %0d/%0d/11", k, o.tt, o.fee, o.vcal, ticks, f);
            end
            n_cmp++;
            if ({o.d0, o.d1, o.d2} !== 3'b010 || o.v1 !== (acc ? 2'b10 : 2'b01) || o.v2 !== o.v1) begin
                n_fail++; $display("FAIL rnd%0d_result got done %b valid %b/%b want 010 %b", k, {o.d0, o.d1, o.d2}, o.v1, o.v2, acc ? 2'b10 : 2'b01);
            end
            for (int i = 0; i < NC; i++) begin
                n_cmp++;
                if (int'(dut.bal_q[i]) !== mbal[i]) begin n_fail++; $display("FAIL rnd%0d_bal[%0d] got %0d want %0d", k, i, dut.bal_q[i], mbal[i]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0]    v;
        logic [BW-1:0] f;
        run_timer(4);
        do_cal(v, f);
        do_topup_idle(0, 50);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if (bus.valid_Epass !== 2'b00 || bus.done !== 1'b0 || bus.fee !== '0 || bus.transit_ticks !== 16'd0) begin
            n_fail++; $display("FAIL mid_reset got %b/%b/%0d/%0d want 00/0/0/0", bus.valid_Epass, bus.done, bus.fee, bus.transit_ticks);
        end
        for (int i = 0; i < NC; i++) begin
            n_cmp++;
            if (int'(dut.bal_q[i]) !== mbal[i]) begin n_fail++; $display("FAIL mid_reset_bal[%0d] got %0d want %0d", i, dut.bal_q[i], mbal[i]); end
        end
        tick();
        reset_n = 1'b1;
        tick();
        n_cmp++;
        if (bus.valid_Epass !== 2'b00) begin n_fail++; $display("FAIL post_reset got %b want 00", bus.valid_Epass); end
    endtask

    initial begin
        bus.init       = 1'b0;
        bus.count      = 1'b0;
        bus.cal        = 1'b0;
        bus.card_valid = 1'b0;
        bus.card_id    = '0;
        bus.topup_en   = 1'b0;
        bus.topup_id   = '0;
        bus.topup_amt  = '0;
        model_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        test_reset();
        reset_n = 1'b1;
        tick();
        test_reset();
        test_nominal();
        test_insufficient();
        test_unknown_timeout();
        test_speeding();
        test_topup_deduct();
        test_abort();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog got no completion want finish before 900000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
